// File: rtl/alu16_pkg.sv
// Shared types and constants for the 16-bit ALU operation sequencer.
// Holds the FSM state enum and the packed request record carried through the queue.
package alu16_pkg;

    localparam int ALU_W = 16;
    localparam int OPC_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RESPOND = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [OPC_W-1:0] opcode;
        logic             mode;
        logic             cin;
    } alu_req_t;

endpackage

// File: rtl/alu16_req_fifo.sv
// Request queue for the ALU sequencer: DEPTH entries of alu_req_t, no bypass,
// so an entry written on an edge is visible at the head only afterwards.
module alu16_req_fifo
    import alu16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  alu_req_t wdata,
    output alu_req_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    alu_req_t    mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        push_s;
    logic        pop_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty  = (wr_ptr_r == rd_ptr_r);
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign rdata  = mem_r[rd_ptr_r[AW-1:0]];

    // Entry storage, cleared on reset so the head never presents stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alu16_op_sequencer.sv
// Sequences queued requests onto an external combinational ALU: drives the pins,
// waits SETTLE_CYCLES edges, captures the outputs and hands them out on a valid/ready port.
module alu16_op_sequencer
    import alu16_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ALU_W-1:0] req_a,
    input  logic [ALU_W-1:0] req_b,
    input  logic [OPC_W-1:0] req_opcode,
    input  logic             req_mode,
    input  logic             req_cin,
    output logic [ALU_W-1:0] operand_a,
    output logic [ALU_W-1:0] operand_b,
    output logic [OPC_W-1:0] opcode,
    output logic             mode,
    output logic             carry_in,
    input  logic [ALU_W-1:0] result,
    input  logic             carry_out,
    input  logic             nBo,
    input  logic             nGo,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_nbo,
    output logic             rsp_ngo,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    seq_state_e       state_r;
    seq_state_e       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic             pop_s;
    logic             capture_s;
    logic             complete_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    alu_req_t         req_s;
    alu_req_t         head_s;

    logic [ALU_W-1:0] operand_a_r;
    logic [ALU_W-1:0] operand_b_r;
    logic [OPC_W-1:0] opcode_r;
    logic             mode_r;
    logic             carry_in_r;
    logic             rsp_valid_r;
    logic [ALU_W-1:0] rsp_result_r;
    logic             rsp_cout_r;
    logic             rsp_nbo_r;
    logic             rsp_ngo_r;
    logic             busy_r;
    logic [15:0]      op_count_r;

    assign req_ready = !fifo_full_s;
    assign push_s    = req_valid && !fifo_full_s;
    assign req_s     = '{a: req_a, b: req_b, opcode: req_opcode, mode: req_mode, cin: req_cin};

    alu16_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (req_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state and per-edge action decode.
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        capture_s  = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_SETTLE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == 4'd1) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_RESPOND;
                end else begin
                    state_nx_s = ST_SETTLE;
                end
            end
            ST_RESPOND: begin
                if (rsp_valid_r && rsp_ready) begin
                    complete_s = 1'b1;
                    // Chain straight into the next queued request without an idle cycle.
                    if (!fifo_empty_s) begin
                        pop_s      = 1'b1;
                        state_nx_s = ST_SETTLE;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_RESPOND;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register and busy flag, which tracks the next state so it is itself a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
        end
    end

    // Settle counter: loaded on every pop, counts down while settling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (pop_s) begin
            cnt_r <= SETTLE_LOAD;
        end else if ((state_r == ST_SETTLE) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // ALU-side pins: only a pop changes them, so they hold between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_a_r <= 16'd0;
            operand_b_r <= 16'd0;
            opcode_r    <= 4'd0;
            mode_r      <= 1'b0;
            carry_in_r  <= 1'b0;
        end else if (pop_s) begin
            operand_a_r <= head_s.a;
            operand_b_r <= head_s.b;
            opcode_r    <= head_s.opcode;
            mode_r      <= head_s.mode;
            carry_in_r  <= head_s.cin;
        end
    end

    // Response capture and completion bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 16'd0;
            rsp_cout_r   <= 1'b0;
            rsp_nbo_r    <= 1'b0;
            rsp_ngo_r    <= 1'b0;
            op_count_r   <= 16'd0;
        end else if (capture_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= result;
            rsp_cout_r   <= carry_out;
            rsp_nbo_r    <= nBo;
            rsp_ngo_r    <= nGo;
        end else if (complete_s) begin
            rsp_valid_r <= 1'b0;
            op_count_r  <= op_count_r + 16'd1;
        end
    end

    assign operand_a  = operand_a_r;
    assign operand_b  = operand_b_r;
    assign opcode     = opcode_r;
    assign mode       = mode_r;
    assign carry_in   = carry_in_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_cout   = rsp_cout_r;
    assign rsp_nbo    = rsp_nbo_r;
    assign rsp_ngo    = rsp_ngo_r;
    assign busy       = busy_r;
    assign op_count   = op_count_r;

endmodule

// File: tb/tb_alu16_op_sequencer.sv
// Self-checking bench for alu16_op_sequencer: stub adder ALU, directed scenarios
// plus randomized traffic scored against a queue-based reference model.
module tb_alu16_op_sequencer;
    import alu16_pkg::*;

    localparam int SETTLE = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = 16'd0;
    logic [15:0] req_b = 16'd0;
    logic [3:0]  req_opcode = 4'd0;
    logic        req_mode = 1'b0;
    logic        req_cin = 1'b0;
    logic [15:0] operand_a, operand_b;
    logic [3:0]  opcode;
    logic        mode, carry_in;
    logic [15:0] result;
    logic        carry_out, nBo, nGo;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_cout, rsp_nbo, rsp_ngo, busy;
    logic [15:0] op_count;
    logic [16:0] alu_sum;

    int          n_checks = 0;
    int          n_errors = 0;
    alu_req_t    exp_q[$];
    logic [15:0] model_cnt = 16'd0;
    bit          mon_en = 1'b0;
    bit          push_done = 1'b0;
    alu_req_t    mon_e;
    logic [16:0] mon_sum;
    alu_req_t    last_req;

    always #5 clk = ~clk;

    // Stub ALU: plain adder with active-low flags held inactive.
    assign alu_sum   = {1'b0, operand_a} + {1'b0, operand_b};
    assign result    = alu_sum[15:0];
    assign carry_out = alu_sum[16];
    assign nBo       = 1'b1;
    assign nGo       = 1'b1;

    alu16_op_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_opcode (req_opcode),
        .req_mode   (req_mode),
        .req_cin    (req_cin),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .opcode     (opcode),
        .mode       (mode),
        .carry_in   (carry_in),
        .result     (result),
        .carry_out  (carry_out),
        .nBo        (nBo),
        .nGo        (nGo),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .rsp_nbo    (rsp_nbo),
        .rsp_ngo    (rsp_ngo),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one request and hold it until accepted; the model queue records it on acceptance.
    task automatic push(input alu_req_t r);
        bit ok;
        ok         = 1'b0;
        req_a      = r.a;
        req_b      = r.b;
        req_opcode = r.opcode;
        req_mode   = r.mode;
        req_cin    = r.cin;
        req_valid  = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (req_ready) begin
                cyc(1);
                exp_q.push_back(r);
                last_req = r;
                ok = 1'b1;
            end else begin
                cyc(1);
            end
        end
        if (!ok) chk("push_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && !busy) break;
            cyc(1);
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    function automatic alu_req_t mk(input logic [15:0] a, input logic [15:0] b);
        alu_req_t r;
        r.a      = a;
        r.b      = b;
        r.opcode = 4'($urandom);
        r.mode   = 1'($urandom);
        r.cin    = 1'($urandom);
        return r;
    endfunction

    function automatic alu_req_t rnd_req();
        logic [15:0] a;
        a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        return mk(a, 16'($urandom));
    endfunction

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_opa"}, 32'(operand_a), 32'd0);
        chk({pfx, "_opb"}, 32'(operand_b), 32'd0);
        chk({pfx, "_opc"}, 32'(opcode), 32'd0);
        chk({pfx, "_mode"}, 32'(mode), 32'd0);
        chk({pfx, "_cin"}, 32'(carry_in), 32'd0);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_rsp_result"}, 32'(rsp_result), 32'd0);
        chk({pfx, "_rsp_cout"}, 32'(rsp_cout), 32'd0);
        chk({pfx, "_rsp_nbo"}, 32'(rsp_nbo), 32'd0);
        chk({pfx, "_rsp_ngo"}, 32'(rsp_ngo), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_op_count"}, 32'(op_count), 32'd0);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Scoreboard: every presented response must match the oldest accepted request.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                chk("op_count", 32'(op_count), 32'(model_cnt));
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_rsp", 32'(rsp_valid), 32'd0);
                    end else begin
                        mon_e   = exp_q[0];
                        mon_sum = 17'(mon_e.a) + 17'(mon_e.b);
                        chk("rsp_result", 32'(rsp_result), 32'(mon_sum[15:0]));
                        chk("rsp_cout", 32'(rsp_cout), 32'(mon_sum[16]));
                        chk("rsp_nbo", 32'(rsp_nbo), 32'd1);
                        chk("rsp_ngo", 32'(rsp_ngo), 32'd1);
                        chk("pin_a", 32'(operand_a), 32'(mon_e.a));
                        chk("pin_b", 32'(operand_b), 32'(mon_e.b));
                        chk("pin_opcode", 32'(opcode), 32'(mon_e.opcode));
                        chk("pin_mode", 32'(mode), 32'(mon_e.mode));
                        chk("pin_cin", 32'(carry_in), 32'(mon_e.cin));
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            model_cnt = model_cnt + 16'd1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        int cycles;

        // Reset state, checked mid-cycle while rst is held.
        #2 rst = 1'b1;
        #10;
        chk_all_zero("rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        // Single operation and its latency from the pop edge.
        rsp_ready = 1'b1;
        push(mk(16'h00FF, 16'h0001));
        req_valid = 1'b0;
        chk("no_bypass_busy", 32'(busy), 32'd0);
        k = 0;
        while (!busy && k < 20) begin
            cyc(1);
            k++;
        end
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            cyc(1);
            lat++;
        end
        chk("latency", 32'(lat), 32'(SETTLE));
        chk("single_result", 32'(rsp_result), 32'h0100);
        chk("single_cout", 32'(rsp_cout), 32'd0);
        drain(50);
        chk("single_count", 32'(op_count), 32'd1);

        // Carry out of bit 15.
        push(mk(16'hFFFF, 16'h0001));
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            cyc(1);
            k++;
        end
        chk("carry_result", 32'(rsp_result), 32'h0000);
        chk("carry_cout", 32'(rsp_cout), 32'd1);
        drain(50);

        // Backpressure: one in flight plus a full queue.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(rnd_req());
        req_valid = 1'b0;
        chk("full_ready", 32'(req_ready), 32'd0);
        req_a     = 16'h1234;
        req_b     = 16'h4321;
        req_valid = 1'b1;
        cyc(3);
        req_valid = 1'b0;
        cyc(3);
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 100) begin
            chk("b2b_busy", 32'(busy), 32'd1);
            cyc(1);
            cycles++;
        end
        chk("b2b_cycles", 32'(cycles), 32'(1 + 4 * (SETTLE + 1)));
        drain(50);
        chk("hold_a", 32'(operand_a), 32'(last_req.a));
        chk("hold_b", 32'(operand_b), 32'(last_req.b));

        // Randomized traffic with random response backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    push(rnd_req());
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid = 1'b0;
                        cyc($urandom_range(1, 4));
                    end
                end
                req_valid = 1'b0;
                push_done = 1'b1;
            end
            begin
                while (!push_done) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    cyc(1);
                end
            end
        join
        rsp_ready = 1'b1;
        drain(400);

        // Counter wrap: preload to 0xFFFF, one more completion wraps to zero.
        #1;
        force dut.op_count_r = 16'hFFFF;
        #1;
        release dut.op_count_r;
        model_cnt = 16'hFFFF;
        push(mk(16'h0010, 16'h0020));
        req_valid = 1'b0;
        drain(50);
        chk("wrap_count", 32'(op_count), 32'h0000);

        // Reset while settling with two requests queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(rnd_req());
        req_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        model_cnt = 16'd0;
        #1;
        chk_all_zero("midop");
        cyc(2);
        rst = 1'b0;
        chk("rel_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        cyc(12);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_count", 32'(op_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
